// File: rtl/avalon_master_pkg.sv
// avalon_master_pkg: shared types and constants for the Avalon-MM master bridge
package avalon_master_pkg;
  typedef enum logic {IDLE, REQUEST} state_e;
  localparam logic [31:0] ERROR_DATA = 32'h0;
  function automatic int pend_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction
endpackage

// File: rtl/avalon_pending_tracker.sv
// avalon_pending_tracker: outstanding-read counter and readdatavalid watchdog
module avalon_pending_tracker
  import avalon_master_pkg::*;
#(
  parameter int MAXPENDING = 4,
  parameter int TIMEOUT    = 255,
  parameter int PW         = pend_width(MAXPENDING)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          issue_read,
  input  logic          readdatavalid,
  output logic [PW-1:0] pending,
  output logic          timeout_pulse
);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [PW-1:0] pending_q, pending_d;
  logic [15:0] wd_q, wd_d;
  logic active, retire;
  always_comb begin
    active        = pending_q != '0;
    timeout_pulse = active && !readdatavalid && wd_q == WD_LAST;
    retire        = active && (readdatavalid || timeout_pulse);
    pending_d     = pending_q + PW'(issue_read) - PW'(retire);
    wd_d          = (active && !retire) ? wd_q + 16'd1 : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pending_q <= '0;
      wd_q      <= '0;
    end else begin
      pending_q <= pending_d;
      wd_q      <= wd_d;
    end
  assign pending = pending_q;
endmodule

// File: rtl/avalon_master_bridge.sv
// avalon_master_bridge: valid/ready command port to Avalon-MM master with
// pipelined reads, bounded outstanding count and read timeout responses
module avalon_master_bridge
  import avalon_master_pkg::*;
#(
  parameter int ADDRESSWIDTH = 4,
  parameter int MAXPENDING   = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESSWIDTH-1:0] cmd_address,
  input  logic [31:0]             cmd_data,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_data,
  output logic                    rsp_error,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [ADDRESSWIDTH-1:0] avm_address,
  output logic [31:0]             avm_writedata,
  input  logic                    avm_waitrequest,
  input  logic                    avm_readdatavalid,
  input  logic [31:0]             avm_readdata,
  output logic                    busy
);
  localparam int PW = pend_width(MAXPENDING);
  state_e state_q, state_d;
  logic cmd_write_q, cmd_write_d;
  logic [ADDRESSWIDTH-1:0] cmd_address_q, cmd_address_d;
  logic [31:0] cmd_data_q, cmd_data_d, rsp_data_q, rsp_data_d;
  logic rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [PW-1:0] pending;
  logic timeout_pulse, in_request, holding_read, done, accept, rdv_hit;
  avalon_pending_tracker #(
    .MAXPENDING(MAXPENDING),
    .TIMEOUT(TIMEOUT),
    .PW(PW)
  ) u_tracker (
    .clk(clk),
    .reset_n(reset_n),
    .issue_read(holding_read && done),
    .readdatavalid(avm_readdatavalid),
    .pending(pending),
    .timeout_pulse(timeout_pulse)
  );
  // a read still on the bus is counted so completion cannot overflow pending
  always_comb begin
    in_request    = state_q == REQUEST;
    holding_read  = in_request && !cmd_write_q;
    done          = in_request && !avm_waitrequest;
    cmd_ready     = reset_n && (!in_request || !avm_waitrequest) &&
                    (int'(pending) + int'(holding_read) < MAXPENDING);
    accept        = cmd_valid && cmd_ready;
    rdv_hit       = avm_readdatavalid && pending != '0;
    state_d       = accept ? REQUEST : done ? IDLE : state_q;
    cmd_write_d   = accept ? cmd_write : cmd_write_q;
    cmd_address_d = accept ? cmd_address : cmd_address_q;
    cmd_data_d    = accept ? cmd_data : cmd_data_q;
    rsp_valid_d   = rdv_hit || timeout_pulse;
    rsp_error_d   = timeout_pulse;
    rsp_data_d    = rdv_hit ? avm_readdata : ERROR_DATA;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q       <= IDLE;
      cmd_write_q   <= 1'b0;
      cmd_address_q <= '0;
      cmd_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_write_q   <= cmd_write_d;
      cmd_address_q <= cmd_address_d;
      cmd_data_q    <= cmd_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_data_q    <= rsp_data_d;
    end
  assign avm_read      = holding_read;
  assign avm_write     = in_request && cmd_write_q;
  assign avm_address   = cmd_address_q;
  assign avm_writedata = cmd_data_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_error     = rsp_error_q;
  assign rsp_data      = rsp_data_q;
  assign busy          = in_request || pending != '0;
endmodule

// File: tb/tb_avalon_master_bridge.sv
// tb_avalon_master_bridge: directed stimulus, scripted slave and a cycle-level
// behavioural model of the bridge compared on every falling edge
module tb_avalon_master_bridge;
  localparam int AW = 4, MAXP = 4, TMO = 8;
  logic clk = 0, reset_n = 1;
  logic cmd_valid = 0, cmd_write = 0, cmd_ready;
  logic [AW-1:0] cmd_address = '0, avm_address;
  logic [31:0] cmd_data = '0, rsp_data, avm_writedata, avm_readdata;
  logic rsp_valid, rsp_error, avm_read, avm_write, busy;
  logic avm_waitrequest = 0, avm_readdatavalid;
  logic q_rdv = 0, man_rdv = 0;
  logic [31:0] q_data = '0, man_data = '0;
  int cyc = 0, lat = 1, n_reads = 0, n_rdv = 0, n_pass = 0, n_total = 0;
  bit mute = 0;
  logic [31:0] mem [16];
  int due_q[$];
  logic [31:0] dat_q[$], rsp_q[$];
  logic err_q[$];
  bit m_req = 0, m_wr = 0, e_rv = 0, e_re = 0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0] m_data = '0, e_rd = '0;
  int m_pend = 0, m_last_clear = 0;
  logic [31:0] exp3 [6] = '{32'h1000_0000, 32'h1000_0001, 32'hA5A5_A5A5,
                            32'h1000_0003, 32'h1000_0004, 32'h0000_5555};

  assign avm_readdatavalid = q_rdv | man_rdv;
  assign avm_readdata      = man_rdv ? man_data : q_data;

  avalon_master_bridge #(.ADDRESSWIDTH(AW), .MAXPENDING(MAXP), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .avm_read(avm_read), .avm_write(avm_write), .avm_address(avm_address),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid), .avm_readdata(avm_readdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input bit w, input logic [AW-1:0] a, input logic [31:0] d);
    bit ok = 0;
    cmd_valid = 1; cmd_write = w; cmd_address = a; cmd_data = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #2;
    end
    cmd_valid = 0;
    if (!ok) begin
      n_total++;
      $display("FAIL send_handshake at cycle %0d: got no cmd_ready expected handshake", cyc);
    end
  endtask

  // slave: memory backed, fixed read latency, optionally never returns data
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
    forever begin
      @(negedge clk);
      if (avm_write && !avm_waitrequest) mem[avm_address] = avm_writedata;
      if (avm_read && !avm_waitrequest) begin
        n_reads++;
        if (!mute) begin
          due_q.push_back(cyc + lat);
          dat_q.push_back(mem[avm_address]);
        end
      end
      @(posedge clk);
      #2;
      q_rdv = 0; q_data = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        q_rdv = 1;
        q_data = dat_q.pop_front();
        void'(due_q.pop_front());
        n_rdv++;
      end
    end
  end

  // model: one transfer on the bus, pending count, watchdog as time since last clear
  initial begin
    bit done, hit, tmo, exp_ready;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_req = 0; m_wr = 0; m_addr = '0; m_data = '0; m_pend = 0;
        e_rv = 0; e_re = 0; e_rd = '0; m_last_clear = cyc;
        chk("rst_avm_read", 32'(avm_read), 32'(0));
        chk("rst_avm_write", 32'(avm_write), 32'(0));
        chk("rst_avm_address", 32'(avm_address), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_data", rsp_data, 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
      end else begin
        if (rsp_valid) begin
          rsp_q.push_back(rsp_data);
          err_q.push_back(rsp_error);
        end
        chk("avm_read", 32'(avm_read), 32'(m_req && !m_wr));
        chk("avm_write", 32'(avm_write), 32'(m_req && m_wr));
        if (m_req) chk("avm_address", 32'(avm_address), 32'(m_addr));
        if (m_req && m_wr) chk("avm_writedata", avm_writedata, m_data);
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        if (e_rv) begin
          chk("rsp_error", 32'(rsp_error), 32'(e_re));
          chk("rsp_data", rsp_data, e_rd);
        end
        chk("busy", 32'(busy), 32'(m_req || m_pend != 0));
        exp_ready = (!m_req || !avm_waitrequest) && (m_pend + int'(m_req && !m_wr) < MAXP);
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        done = m_req && !avm_waitrequest;
        hit  = avm_readdatavalid && m_pend > 0;
        tmo  = m_pend > 0 && !avm_readdatavalid && (cyc - m_last_clear) == TMO;
        e_rv = hit || tmo; e_re = tmo; e_rd = hit ? avm_readdata : 32'h0;
        if (m_pend == 0 || e_rv) m_last_clear = cyc;
        m_pend = m_pend + int'(done && !m_wr) - int'(e_rv);
        if (cmd_valid && exp_ready) begin
          m_req = 1; m_wr = cmd_write; m_addr = cmd_address; m_data = cmd_data;
        end else if (done) m_req = 0;
      end
    end
  end

  initial begin
    int n0, base, zeros;
    #1 reset_n = 0;
    tick(3);
    chk("init_avm_read", 32'(avm_read), 32'(0));
    chk("init_rsp_valid", 32'(rsp_valid), 32'(0));
    reset_n = 1;
    tick(2);
    // write then read back through a zero-wait slave
    send(1, 4'h2, 32'hA5A5_A5A5);
    #1;
    chk("t1_write", 32'(avm_write), 32'(1));
    chk("t1_addr", 32'(avm_address), 32'h2);
    chk("t1_wdata", avm_writedata, 32'hA5A5_A5A5);
    tick(1);
    #1 chk("t1_write_one_cycle", 32'(avm_write), 32'(0));
    send(0, 4'h2, 32'h0);
    tick(2);
    #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("t1_rsp_data", rsp_data, 32'hA5A5_A5A5);
    chk("t1_rsp_error", 32'(rsp_error), 32'(0));
    tick(2);
    // write stalled three cycles by waitrequest
    avm_waitrequest = 1;
    send(1, 4'h5, 32'h0000_5555);
    cmd_valid = 1; cmd_write = 1; cmd_address = 4'h6; cmd_data = 32'h0000_6666;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_hold_write", 32'(avm_write), 32'(1));
      chk("t2_hold_addr", 32'(avm_address), 32'h5);
      chk("t2_hold_data", avm_writedata, 32'h0000_5555);
      chk("t2_ready_low", 32'(cmd_ready), 32'(0));
      tick(1);
    end
    avm_waitrequest = 0;
    #1 chk("t2_ready_high", 32'(cmd_ready), 32'(1));
    tick(1);
    cmd_valid = 0;
    #1;
    chk("t2_next_write", 32'(avm_write), 32'(1));
    chk("t2_next_addr", 32'(avm_address), 32'h6);
    chk("t2_next_data", avm_writedata, 32'h0000_6666);
    tick(2);
    // six reads, latency five, limited to four outstanding
    lat = 5; n0 = n_reads; base = rsp_q.size(); zeros = 0;
    for (int a = 0; a < 4; a++) send(0, AW'(a), 32'h0);
    cmd_valid = 1; cmd_write = 0; cmd_address = 4'h4;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (cmd_ready) break;
      zeros++;
      tick(1);
    end
    chk("t3_reads_issued", 32'(n_reads - n0), 32'(4));
    chk("t3_ready_low_cycles", 32'(zeros), 32'(3));
    send(0, 4'h4, 32'h0);
    send(0, 4'h5, 32'h0);
    for (int i = 0; i < 60 && rsp_q.size() < base + 6; i++) tick(1);
    chk("t3_rsp_count", 32'(rsp_q.size()), 32'(base + 6));
    if (rsp_q.size() >= base + 6)
      for (int i = 0; i < 6; i++) begin
        chk("t3_rsp_data", rsp_q[base + i], exp3[i]);
        chk("t3_rsp_err", 32'(err_q[base + i]), 32'(0));
      end
    tick(2);
    // silent slave: read retires as an error
    mute = 1;
    send(0, 4'h3, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      #1 chk("t4_no_rsp_yet", 32'(rsp_valid), 32'(0));
    end
    tick(1);
    #1;
    chk("t4_tmo_valid", 32'(rsp_valid), 32'(1));
    chk("t4_tmo_error", 32'(rsp_error), 32'(1));
    chk("t4_tmo_data", rsp_data, 32'h0);
    tick(1);
    #1 chk("t4_idle_busy", 32'(busy), 32'(0));
    tick(1);
    // data arriving on the expiry cycle wins over the timeout
    send(0, 4'h4, 32'h0);
    tick(8);
    man_rdv = 1; man_data = 32'hCAFE_0004;
    tick(1);
    man_rdv = 0;
    #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("t5_rsp_error", 32'(rsp_error), 32'(0));
    chk("t5_rsp_data", rsp_data, 32'hCAFE_0004);
    tick(1);
    #1 chk("t5_busy", 32'(busy), 32'(0));
    tick(1);
    man_rdv = 1; man_data = 32'hBAD0_BAD0;
    tick(1);
    man_rdv = 0;
    #1 chk("t5_stray_ignored", 32'(rsp_valid), 32'(0));
    tick(2);
    // reset while a read is stalled with two outstanding
    mute = 0; lat = 10;
    send(0, 4'h0, 32'h0);
    send(0, 4'h1, 32'h0);
    send(0, 4'h2, 32'h0);
    avm_waitrequest = 1;
    #1;
    chk("t6_pre_read", 32'(avm_read), 32'(1));
    chk("t6_pre_busy", 32'(busy), 32'(1));
    reset_n = 0;
    #1;
    chk("t6_async_read", 32'(avm_read), 32'(0));
    chk("t6_async_busy", 32'(busy), 32'(0));
    chk("t6_async_ready", 32'(cmd_ready), 32'(0));
    tick(2);
    reset_n = 1; avm_waitrequest = 0; lat = 3;
    base = rsp_q.size();
    tick(12);
    chk("t6_late_ignored", 32'(rsp_q.size()), 32'(base));
    send(0, 4'h7, 32'h0);
    for (int i = 0; i < 20 && rsp_q.size() < base + 1; i++) tick(1);
    chk("t6_new_rsp_count", 32'(rsp_q.size()), 32'(base + 1));
    if (rsp_q.size() >= base + 1) begin
      chk("t6_new_data", rsp_q[base], 32'h1000_0007);
      chk("t6_new_err", 32'(err_q[base]), 32'(0));
    end
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/avalon_master_bridge.md
# avalon_master_bridge

Avalon-MM initiator for driving the peripheral register space. Accepts single-beat read/write commands on a valid/ready command port and issues them as Avalon-MM transfers with waitrequest and pipelined readdatavalid. Returns read data, or a timeout error, on a response port. It sits on the host side and pairs with the peripheral's Avalon register slave for bring-up, self-test and DMA-style register sequencing.

## Interface
Parameters:
- ADDRESSWIDTH, 4, Avalon word address width
- MAXPENDING, 4, max reads issued but not yet returned (1..15)
- TIMEOUT, 255, cycles without readdatavalid before the oldest pending read is retired as an error (1..65535)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_write  in  1  1=write, 0=read
- cmd_address  in  ADDRESSWIDTH  word address
- cmd_data  in  32  write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_data  out  32  read data, 0 on error
- rsp_error  out  1  qualifies rsp_valid: read timed out
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_address  out  ADDRESSWIDTH  Avalon address
- avm_writedata  out  32  Avalon write data
- avm_waitrequest  in  1  slave stall
- avm_readdatavalid  in  1  read data strobe
- avm_readdata  in  32  read data
- busy  out  1  REQUEST state or pending != 0

## Operation
- FSM states: IDLE, REQUEST.
- IDLE: avm_read and avm_write are 0. On a cmd handshake, register the command and go to REQUEST.
- REQUEST: drive avm_read = !cmd_q_write and avm_write = cmd_q_write from the registered command.
  - While avm_waitrequest = 1, all avm_* outputs hold stable.
  - When avm_waitrequest = 0, the transfer completes. A completed read increments pending.
  - After completion: if a new command handshakes in the same cycle, stay in REQUEST with the new command. Otherwise go to IDLE.
- holding_read = (state == REQUEST && !cmd_q_write).
- cmd_ready = reset_n && (state == IDLE || !avm_waitrequest) && (pending + holding_read < MAXPENDING).
  - cmd_ready is combinational from avm_waitrequest.
  - The MAXPENDING limit applies to writes as well as reads.
- Response on avm_readdatavalid: next cycle, rsp_valid = 1, rsp_data = avm_readdata, rsp_error = 0; pending decrements.
- Simultaneous read completion and readdatavalid: pending is unchanged.
- Watchdog counter:
  - Counts while pending != 0.
  - Clears on readdatavalid or when pending = 0.
  - On reaching TIMEOUT: rsp_valid = 1, rsp_error = 1, rsp_data = 0; pending decrements; counter clears.
  - If readdatavalid arrives in the same cycle, readdatavalid wins and no error is emitted.
- Stray readdatavalid while pending = 0 is ignored: no response, no underflow.
- Reads are in order; a timed-out read is retired as the oldest.
- Late data from a timed-out read is not tracked; it is attributed to the next pending read. Software resets the bridge after any error.
- Writes produce no response.

## Timing
- Reset (async assert, sync deassert):
  - state = IDLE, pending = 0, watchdog = 0.
  - rsp_valid, rsp_error, avm_read, avm_write, busy = 0.
  - rsp_data, avm_address, avm_writedata = 0.
  - cmd_ready = 0 while reset_n is low.
- Reset mid-transfer: the request drops immediately; outstanding reads are abandoned; later readdatavalid strobes are ignored.
- Command handshake at cycle N: avm_read/avm_write is asserted at N+1.
- Zero-wait slave: sustains one transfer per cycle, limited only by MAXPENDING.
- readdatavalid at cycle M: rsp_valid at M+1.
- Timeout: error response TIMEOUT+1 cycles after the last event that cleared the watchdog.
- All outputs except cmd_ready are registered.

## Structure
- Package avalon_master_pkg holds:
  - state enum (IDLE, REQUEST)
  - MAXPENDING count width function
  - ERROR_DATA = 32'h0
- Sub-module avalon_pending_tracker owns the pending counter and watchdog.
  - Inputs: issue_read, readdatavalid.
  - Outputs: pending, timeout_pulse.
- Top level holds the FSM, command register and response register.

## Test plan
- Zero-wait slave; write 0x2 ← 0xA5A5A5A5, then read 0x2 with 1-cycle readdatavalid -> avm_write one cycle with correct address/data; rsp_valid with 0xA5A5A5A5 and rsp_error = 0, 2 cycles after avm_read.
- Waitrequest held 3 cycles on a write -> avm_address/writedata/write stable all 3 cycles; cmd_ready = 0 until waitrequest drops; next command is issued the following cycle.
- 6 back-to-back reads with MAXPENDING = 4 and 5-cycle read latency -> exactly 4 reads issued; cmd_ready = 0 until the first readdatavalid; 6 responses returned in order.
- TIMEOUT = 8, slave never returns data -> rsp_valid with rsp_error = 1 and rsp_data = 0 exactly 9 cycles after read completion; pending returns to 0; busy = 0.
- Readdatavalid coincident with watchdog expiry -> normal data response, no error; stray readdatavalid with pending = 0 -> no rsp_valid.
- reset_n pulsed low while in REQUEST with 2 reads pending -> outputs zero asynchronously; after release, late readdatavalid produces no response; a new read completes normally.
